// File: rtl/int_claim_gateway_pkg.sv
// -----------------------------------------------------------------------------
// int_gw_pkg
// Shared types and helpers for the interrupt claim gateway.
//   src_state_t : per-source lifecycle state
//   ID_NONE     : claim/complete ID meaning "no source"
//   idx_to_id   : source index (0-based) -> source ID (1-based)
//   id_to_idx   : source ID -> index, or -1 when the ID names no source
// -----------------------------------------------------------------------------
package int_gw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2
    } src_state_t;

    localparam int ID_NONE = 0;

    function automatic int idx_to_id(input int idx);
        return idx + 1;
    endfunction

    function automatic int id_to_idx(input int id, input int n_src);
        return ((id >= 1) && (id <= n_src)) ? (id - 1) : -1;
    endfunction

endpackage

// File: rtl/int_claim_gateway_if.sv
// -----------------------------------------------------------------------------
// int_claim_gateway_if
// Claim/complete handshake between the interrupt target and the gateway.
//   claim_req        : target -> gateway, one-cycle claim strobe
//   claim_resp_valid : gateway -> target, response strobe one cycle later
//   claim_id         : gateway -> target, claimed ID (0 = nothing eligible)
//   complete_valid   : target -> gateway, completion strobe
//   complete_id      : target -> gateway, ID being completed
// Modports: master = interrupt target, slave = gateway.
// -----------------------------------------------------------------------------
interface int_claim_gateway_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = $clog2(N_SRC + 1);

    logic            claim_req;
    logic            claim_resp_valid;
    logic [ID_W-1:0] claim_id;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;

    modport master (
        output claim_req,
        output complete_valid,
        output complete_id,
        input  claim_resp_valid,
        input  claim_id
    );

    modport slave (
        input  claim_req,
        input  complete_valid,
        input  complete_id,
        output claim_resp_valid,
        output claim_id
    );

endinterface

// File: rtl/int_claim_gateway_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick over a request vector.
//   req         : request bits, one per index
//   ptr         : highest-priority index for this search
//   grant_valid : some request was found
//   grant_idx   : first requesting index at or after ptr, wrapping mod N
// The pointer register lives in the parent.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/int_claim_gateway.sv
// -----------------------------------------------------------------------------
// int_claim_gateway
// Gateway and round-robin scheduler for N_SRC level interrupts feeding one
// target through a claim/complete handshake.
//   clock, reset : clock and synchronous active-high reset
//   src_irq      : level interrupts, bit i is source ID i+1
//   src_enable   : per-source enable mask
//   bus          : claim/complete handshake (slave side)
//   irq_out      : registered OR of eligible sources
//
// Per-source state table:
//   state    | meaning
//   IDLE     | no interrupt held; a high enabled level pends it
//   PENDING  | waiting for a claim; eligible only while enabled
//   INFLIGHT | claimed by the target; waits for its completion
// -----------------------------------------------------------------------------
module int_claim_gateway
    import int_gw_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_irq,
    input  logic [N_SRC-1:0]     src_enable,
    int_claim_gateway_if.slave   bus,
    output logic                 irq_out
);

    localparam int ID_W  = $clog2(N_SRC + 1);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    src_state_t       state [N_SRC];
    logic [N_SRC-1:0] eligible;
    logic [PTR_W-1:0] rr_ptr;
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    int               comp_idx;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = (state[i] == PENDING) && src_enable[i];
        end
    end

    // Out-of-range IDs (0 or above N_SRC) map to -1 and match no source.
    always_comb begin
        comp_idx = -1;
        if (bus.complete_valid) begin
            comp_idx = id_to_idx(int'(bus.complete_id), N_SRC);
        end
    end

    rr_arbiter #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                state[i] <= IDLE;
            end
            rr_ptr               <= '0;
            irq_out              <= 1'b0;
            bus.claim_resp_valid <= 1'b0;
            bus.claim_id         <= ID_W'(ID_NONE);
        end else begin
            irq_out              <= |eligible;
            bus.claim_resp_valid <= bus.claim_req;

            if (bus.claim_req) begin
                if (grant_valid) begin
                    bus.claim_id <= ID_W'(idx_to_id(int'(grant_idx)));
                    rr_ptr       <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0
                                                                     : grant_idx + PTR_W'(1);
                end else begin
                    bus.claim_id <= ID_W'(ID_NONE);
                end
            end

            // A completed source only leaves INFLIGHT here; a still-high
            // level re-pends it on the following edge.
            for (int i = 0; i < N_SRC; i++) begin
                unique case (state[i])
                    IDLE: begin
                        if (src_irq[i] && src_enable[i]) state[i] <= PENDING;
                    end
                    PENDING: begin
                        if (bus.claim_req && grant_valid && (grant_idx == PTR_W'(i)))
                            state[i] <= INFLIGHT;
                    end
                    INFLIGHT: begin
                        if (comp_idx == i) state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_claim_gateway.sv
module tb_int_claim_gateway;

    localparam int N_SRC = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_SRC-1:0] src_irq = '0;
    logic [N_SRC-1:0] src_enable = '1;
    logic             irq_out;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];
    int last_id = 0;

    int_claim_gateway_if #(.N_SRC(N_SRC)) bus ();

    int_claim_gateway #(.N_SRC(N_SRC)) dut (
        .clock      (clock),
        .reset      (reset),
        .src_irq    (src_irq),
        .src_enable (src_enable),
        .bus        (bus.slave),
        .irq_out    (irq_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic claim(input int exp_id);
        bus.claim_req = 1'b1;
        exp_q.push_back(exp_id);
        tick();
        bus.claim_req = 1'b0;
    endtask

    task automatic complete(input int id);
        bus.complete_valid = 1'b1;
        bus.complete_id    = 3'(id);
        tick();
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;
    endtask

    task automatic pulse_irq(input logic [N_SRC-1:0] v);
        src_irq = v;
        tick();
        src_irq = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Response scoreboard: every strobe pops one expected ID; otherwise
    // claim_id must hold its last value.
    always begin
        logic rst_seen;
        int   exp_id;
        @(posedge clock);
        rst_seen = reset;
        #1;
        if (rst_seen) begin
            last_id = 0;
        end else if (bus.claim_resp_valid) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL resp_unexpected: observed strobe with id %0d expected none", bus.claim_id);
            end
            if (exp_q.size() != 0) begin
                exp_id = exp_q.pop_front();
                check("claim_id", 32'(bus.claim_id), 32'(exp_id));
                last_id = exp_id;
            end
        end else begin
            check("claim_id_hold", 32'(bus.claim_id), 32'(last_id));
        end
    end

    initial begin
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        check("rst_irq_out", 32'(irq_out), 0);
        check("rst_resp_valid", 32'(bus.claim_resp_valid), 0);
        check("rst_claim_id", 32'(bus.claim_id), 0);
        claim(0);
        check("idle_irq_out", 32'(irq_out), 0);
        tick();
        check("idle_resp_drop", 32'(bus.claim_resp_valid), 0);

        // Single source, level stays high through the complete
        src_irq = 4'b0100;
        tick();
        check("single_irq_lat1", 32'(irq_out), 0);
        tick();
        check("single_irq_lat2", 32'(irq_out), 1);
        claim(3);
        check("single_irq_resp_edge", 32'(irq_out), 1);
        tick();
        check("single_irq_drop", 32'(irq_out), 0);
        complete(3);
        check("repend_irq_a", 32'(irq_out), 0);
        tick();
        check("repend_irq_b", 32'(irq_out), 0);
        tick();
        check("repend_irq_c", 32'(irq_out), 1);
        src_irq = '0;
        claim(3);
        complete(3);

        // Round-robin
        do_reset();
        pulse_irq(4'b1011);
        claim(1);
        claim(2);
        claim(4);
        claim(0);
        complete(1);
        complete(2);
        complete(4);
        pulse_irq(4'b0001);
        claim(1);
        complete(1);
        pulse_irq(4'b0011);
        claim(2);
        claim(1);
        complete(1);
        complete(2);
        tick();
        check("rr_idle_irq", 32'(irq_out), 0);

        // Masking: pended while enabled, then disabled
        pulse_irq(4'b0010);
        src_enable = 4'b1101;
        tick();
        check("mask_irq_a", 32'(irq_out), 0);
        tick();
        check("mask_irq_b", 32'(irq_out), 0);
        claim(0);
        src_enable = 4'b1111;
        tick();
        check("unmask_irq", 32'(irq_out), 1);
        claim(2);
        complete(2);

        // Claim and complete in the same cycle
        pulse_irq(4'b0001);
        claim(1);
        pulse_irq(4'b0100);
        bus.complete_valid = 1'b1;
        bus.complete_id    = 3'd1;
        claim(3);
        bus.complete_valid = 1'b0;
        bus.complete_id    = '0;
        claim(0);
        pulse_irq(4'b0001);
        claim(1);

        // Ignored completions: 1 and 3 stay INFLIGHT
        complete(0);
        complete(5);
        complete(7);
        complete(2);
        claim(0);
        pulse_irq(4'b1111);
        claim(2);
        claim(4);
        claim(0);
        complete(1);
        complete(2);
        complete(3);
        complete(4);
        tick();
        check("ign_idle_irq", 32'(irq_out), 0);

        // Reset mid-handshake
        pulse_irq(4'b0010);
        claim(2);
        reset         = 1'b1;
        bus.claim_req = 1'b1;
        tick();
        reset         = 1'b0;
        bus.claim_req = 1'b0;
        check("mid_rst_resp", 32'(bus.claim_resp_valid), 0);
        check("mid_rst_id", 32'(bus.claim_id), 0);
        check("mid_rst_irq", 32'(irq_out), 0);
        tick();
        check("mid_rst_resp_next", 32'(bus.claim_resp_valid), 0);
        complete(2);
        pulse_irq(4'b0110);
        tick();
        check("post_rst_irq", 32'(irq_out), 1);
        claim(2);
        claim(3);
        claim(0);
        tick();
        tick();

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL resp_missing: observed %0d unanswered claims expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
